spec_chain_array: RTL and testbench
===================================

Name: spec_chain_array

Overview:
- Parametrised successor of the synthetic per-channel spec blocks used in the specification-mining case studies.
- Holds N_CH independent 2-bit-in/2-bit-out channels. Each channel is a small trigger/wait/fire FSM with hold, abort and optional channel-to-channel chaining.
- Also reports a shared fire-event counter and an aggregate busy flag.
- Gives the miners known temporal properties (next, until, bounded-eventually) with tunable depth.

Parameters:
- N_CH, 10, number of channels (>=1).
- DELAY, 3, WAIT cycles between trigger and fire, excluding hold cycles (>=1).
- CHAIN, 0, 1 = channel i-1 firing also triggers channel i; 0 = channels fully independent.
- CNT_W, 8, width of fire_total.

Ports:
- clock  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- a  input  2*N_CH  channel i command at a[2i+1:2i]: 00 idle, 01 trigger, 10 hold, 11 abort.
- c  output  2*N_CH  channel i status at c[2i+1:2i]: 00 idle, 01 busy, 10 done pulse, 11 abort-ack pulse.
- any_busy  output  1  registered OR of (channel in WAIT) over all channels.
- fire_total  output  CNT_W  running count of done pulses, modulo 2^CNT_W.

Behaviour:
- Reset:
  - reset_n sampled low at an edge puts every channel in IDLE with cnt=0.
  - At that edge: c=0, any_busy=0, fire_total=0.
  - Reset mid-WAIT abandons silently: no abort-ack, no done.
- Outputs: all registered. c is decoded from channel state only: IDLE 00, WAIT 01, FIRE 10, ABORT 11.
- Per-channel FSM (cmd = a slice sampled at edge; trig = cmd==01, or CHAIN=1 and i>=1 and channel i-1 currently in FIRE):
  - IDLE: trig -> WAIT with cnt=DELAY. Hold and abort are ignored.
  - WAIT:
    - cmd==11 -> ABORT; abort beats everything.
    - cmd==10 -> stay, cnt frozen.
    - Otherwise, if cnt==1 -> FIRE; else cnt-1, stay.
    - trig while in WAIT is ignored; there is no restart.
  - FIRE (one cycle): trig -> WAIT with cnt=DELAY (back-to-back allowed). Otherwise -> IDLE. Abort ignored.
  - ABORT (one cycle): -> IDLE unconditionally. A trigger in this cycle is dropped.
- Latency: trigger sampled at edge t gives c=01 for cycles t..t+DELAY-1 (plus one per hold cycle) and c=10 at cycle t+DELAY.
- Chaining:
  - A chained trigger is seen in the same cycle that channel i-1 shows c=10, so channel i enters WAIT one cycle after i-1 fires.
  - Channel 0 is never chain-triggered.
  - A chained trigger coinciding with abort on channel i's own a: abort applies only if channel i is in WAIT; otherwise the trigger wins.
- fire_total:
  - Each edge adds popcount(channels in FIRE) to fire_total, modulo 2^CNT_W.
  - Several simultaneous fires add in one cycle; wrap-around is silent.
- any_busy: registered from next-state. It is high in exactly the cycles where at least one c slice reads 01.
- Width rule: cnt is clog2(DELAY+1) bits wide per channel. The popcount adder is clog2(N_CH+1) bits, zero-extended to CNT_W.

Test Plan:
- Basic fire: DELAY=3; ch0 a=01 for 1 cycle, then 00 -> c[1:0] = 01,01,01,10,00; fire_total 0->1; any_busy high exactly 3 cycles.
- Hold: DELAY=3; trigger, then a=10 for 2 cycles mid-WAIT -> c=01 for 5 cycles, then 10 once; fire_total=1.
- Abort vs hold:
  - Trigger, then a=11 on the 2nd WAIT cycle -> c=01,01,11,00; fire_total unchanged at 0.
  - a=11 in IDLE -> c stays 00.
- Back-to-back and ignored retrigger:
  - a=01 held high continuously, DELAY=2 -> c = 01,01,10,01,01,10,...
  - fire_total increments every 3rd cycle.
- Chain: CHAIN=1, N_CH=3, DELAY=1; trigger ch0 only -> ch0 fires at cycle 1, ch1 at 3, ch2 at 5; fire_total=3.
- Wrap and reset:
  - CNT_W=2, N_CH=10; trigger all 10 channels together -> after fire, fire_total = 10 mod 4 = 2.
  - reset_n low mid-WAIT -> next cycle all c=0, any_busy=0, fire_total=0, no 11 pulse.

Source files
------------

// File: rtl/spec_chain_array.sv
// Array of independent trigger/wait/fire channels with optional neighbour chaining,
// a shared fire-event counter and an aggregate busy flag.
module spec_chain_array #(
   parameter int N_CH  = 10,
   parameter int DELAY = 3,
   parameter bit CHAIN = 1'b0,
   parameter int CNT_W = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [2*N_CH-1:0]   a,
   output logic [2*N_CH-1:0]   c,
   output logic                any_busy,
   output logic [CNT_W-1:0]    fire_total
);
   localparam int CW = $clog2(DELAY + 1);
   localparam int PW = $clog2(N_CH + 1);
   localparam int SW = (CNT_W > PW) ? CNT_W : PW;
   localparam logic [CW-1:0] DELAY_V = CW'(DELAY);

   // state encoding doubles as the c status code, so c is just the state register
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_FIRE  = 2'b10,
      ST_ABORT = 2'b11
   } state_t;

   state_t                 state_r [N_CH];
   state_t                 state_s [N_CH];
   logic [CW-1:0]          cnt_r   [N_CH];
   logic [CW-1:0]          cnt_s   [N_CH];
   logic [N_CH-1:0][1:0]   cmd_s;
   logic [N_CH-1:0]        trig_s;
   logic [PW-1:0]          fire_cnt_s;
   logic                   busy_s;
   logic [SW-1:0]          fire_sum_s;

   assign cmd_s = a;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      if (CHAIN && (g >= 1)) begin : g_chain
         assign trig_s[g] = (cmd_s[g] == 2'b01) || (state_r[g-1] == ST_FIRE);
      end else begin : g_solo
         assign trig_s[g] = (cmd_s[g] == 2'b01);
      end
      assign c[2*g+1 -: 2] = state_r[g];
   end

   // next-state for every channel plus the aggregate busy/fire terms derived from it
   always_comb begin
      busy_s     = 1'b0;
      fire_cnt_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_s[i] = state_r[i];
         cnt_s[i]   = cnt_r[i];
         case (state_r[i])
            ST_IDLE: begin
               if (trig_s[i]) begin
                  state_s[i] = ST_WAIT;
                  cnt_s[i]   = DELAY_V;
               end else begin
                  state_s[i] = ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cmd_s[i] == 2'b11) begin
                  state_s[i] = ST_ABORT;
               end else if (cmd_s[i] == 2'b10) begin
                  state_s[i] = ST_WAIT;
               end else if (cnt_r[i] == CW'(1)) begin
                  state_s[i] = ST_FIRE;
               end else begin
                  cnt_s[i] = cnt_r[i] - CW'(1);
               end
            end
            ST_FIRE: begin
               if (trig_s[i]) begin
                  state_s[i] = ST_WAIT;
                  cnt_s[i]   = DELAY_V;
               end else begin
                  state_s[i] = ST_IDLE;
               end
            end
            ST_ABORT: state_s[i] = ST_IDLE;
            default:  state_s[i] = ST_IDLE;
         endcase
         busy_s     = busy_s | (state_s[i] == ST_WAIT);
         fire_cnt_s = fire_cnt_s + PW'(state_s[i] == ST_FIRE);
      end
   end

   // fire_total tracks the done pulses as they appear on c; wrap is silent
   assign fire_sum_s = SW'(fire_total) + SW'(fire_cnt_s);

   // register channel state, counters and aggregate outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) begin
            state_r[i] <= ST_IDLE;
            cnt_r[i]   <= '0;
         end
         any_busy   <= 1'b0;
         fire_total <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_r[i] <= state_s[i];
            cnt_r[i]   <= cnt_s[i];
         end
         any_busy   <= busy_s;
         fire_total <= fire_sum_s[CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_spec_chain_array.sv
// Randomised and directed bench for spec_chain_array against a per-channel
// countdown model; chaining enabled and a narrow counter so wrap is reachable.
module tb_spec_chain_array;
   localparam int N   = 4;
   localparam int DLY = 3;
   localparam bit CHN = 1'b1;
   localparam int CW  = 3;

   logic             clock;
   logic             reset_n;
   logic [2*N-1:0]   a;
   logic [2*N-1:0]   c;
   logic             any_busy;
   logic [CW-1:0]    fire_total;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // model: cycles of countdown left, plus one-cycle done / abort-ack flags
   int rem_m   [N];
   bit fire_m  [N];
   bit abt_m   [N];
   bit was_fire[N];
   int total_m = 0;
   logic [2*N-1:0] exp_c;
   logic           exp_busy;

   spec_chain_array #(.N_CH(N), .DELAY(DLY), .CHAIN(CHN), .CNT_W(CW)) dut (
      .clock(clock), .reset_n(reset_n), .a(a), .c(c),
      .any_busy(any_busy), .fire_total(fire_total)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rem_m[i] = 0; fire_m[i] = 1'b0; abt_m[i] = 1'b0;
      end
   end

   // reference model advances on each rising edge from the sampled inputs
   always @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            rem_m[i] = 0; fire_m[i] = 1'b0; abt_m[i] = 1'b0;
         end
         total_m = 0;
      end else begin
         int fires;
         fires = 0;
         for (int i = 0; i < N; i++) was_fire[i] = fire_m[i];
         for (int i = 0; i < N; i++) begin
            logic [1:0] cmd;
            bit trig;
            cmd  = a[2*i +: 2];
            trig = (cmd == 2'd1) || (CHN && i > 0 && was_fire[i-1]);
            if (rem_m[i] > 0) begin
               if (cmd == 2'd3) begin
                  rem_m[i] = 0; abt_m[i] = 1'b1;
               end else if (cmd == 2'd2) begin
                  rem_m[i] = rem_m[i];
               end else if (rem_m[i] == 1) begin
                  rem_m[i] = 0; fire_m[i] = 1'b1;
               end else begin
                  rem_m[i] = rem_m[i] - 1;
               end
            end else if (abt_m[i]) begin
               abt_m[i] = 1'b0;
            end else begin
               fire_m[i] = 1'b0;
               if (trig) rem_m[i] = DLY;
            end
            if (fire_m[i]) fires++;
         end
         total_m = (total_m + fires) % (1 << CW);
      end
   end

   // single compare point, away from the active edge
   always @(negedge clock) begin
      if (check_en) begin
         exp_busy = 1'b0;
         for (int i = 0; i < N; i++) begin
            exp_c[2*i +: 2] = abt_m[i] ? 2'd3 : fire_m[i] ? 2'd2 : (rem_m[i] > 0) ? 2'd1 : 2'd0;
            if (rem_m[i] > 0) exp_busy = 1'b1;
         end
         check("c_model", 32'(c), 32'(exp_c));
         check("busy_model", 32'(any_busy), 32'(exp_busy));
         check("total_model", 32'(fire_total), 32'(total_m));
      end
   end

   function automatic logic [2*N-1:0] cmd_on(input int ch, input logic [1:0] cmd);
      logic [2*N-1:0] v;
      v = '0;
      v[2*ch +: 2] = cmd;
      return v;
   endfunction

   task automatic apply(input logic [2*N-1:0] av);
      a = av;
      @(negedge clock);
   endtask

   task automatic step3(input logic [1:0] cmd, input logic [1:0] exp, input string nm);
      apply(cmd_on(3, cmd));
      check(nm, 32'(c[7:6]), 32'(exp));
   endtask

   initial begin
      a = '0;
      reset_n = 1'b0;
      @(negedge clock);
      check_en = 1'b1;
      apply('0);
      check("reset_c", 32'(c), 32'd0);
      check("reset_busy", 32'(any_busy), 32'd0);
      check("reset_total", 32'(fire_total), 32'd0);
      reset_n = 1'b1;

      // basic fire on channel 3
      step3(2'd1, 2'd1, "basic_w1");
      check("basic_busy", 32'(any_busy), 32'd1);
      step3(2'd0, 2'd1, "basic_w2");
      step3(2'd0, 2'd1, "basic_w3");
      step3(2'd0, 2'd2, "basic_fire");
      check("basic_total", 32'(fire_total), 32'd1);
      check("basic_idle_busy", 32'(any_busy), 32'd0);
      step3(2'd0, 2'd0, "basic_idle");

      // hold freezes the countdown
      step3(2'd1, 2'd1, "hold_w1");
      step3(2'd2, 2'd1, "hold_h1");
      step3(2'd2, 2'd1, "hold_h2");
      step3(2'd0, 2'd1, "hold_w2");
      step3(2'd0, 2'd1, "hold_w3");
      step3(2'd0, 2'd2, "hold_fire");
      check("hold_total", 32'(fire_total), 32'd2);
      step3(2'd0, 2'd0, "hold_idle");

      // abort in WAIT, then abort in IDLE
      step3(2'd1, 2'd1, "abort_w1");
      step3(2'd0, 2'd1, "abort_w2");
      step3(2'd3, 2'd3, "abort_ack");
      step3(2'd0, 2'd0, "abort_idle");
      step3(2'd3, 2'd0, "abort_in_idle");
      check("abort_total", 32'(fire_total), 32'd2);

      // continuous trigger: back-to-back firing, retrigger in WAIT ignored
      for (int k = 0; k < 8; k++)
         step3(2'd1, (k % 4 == 3) ? 2'd2 : 2'd1, "b2b");
      step3(2'd0, 2'd0, "b2b_idle");
      check("b2b_total", 32'(fire_total), 32'd4);

      // chain ripple from channel 0; four fires wrap the 3-bit counter to 0
      apply(cmd_on(0, 2'd1));
      for (int k = 1; k < 16; k++) begin
         apply('0);
         if (k == 3)  check("chain_ch0", 32'(c[1:0]), 32'd2);
         if (k == 7)  check("chain_ch1", 32'(c[3:2]), 32'd2);
         if (k == 11) check("chain_ch2", 32'(c[5:4]), 32'd2);
         if (k == 15) begin
            check("chain_ch3", 32'(c[7:6]), 32'd2);
            check("chain_wrap", 32'(fire_total), 32'd0);
         end
      end
      apply('0);

      // chained trigger beats abort on an idle channel; abort wins once in WAIT
      apply(cmd_on(0, 2'd1));
      apply('0);
      apply('0);
      apply('0);
      check("cab_ch0_fire", 32'(c[1:0]), 32'd2);
      apply(cmd_on(1, 2'd3));
      check("cab_trig_wins", 32'(c[3:2]), 32'd1);
      apply(cmd_on(1, 2'd3));
      check("cab_abort", 32'(c[3:2]), 32'd3);
      apply('0);
      check("cab_total", 32'(fire_total), 32'd1);

      // reset in the middle of WAIT abandons silently
      apply({N{2'b01}});
      apply('0);
      reset_n = 1'b0;
      apply('0);
      check("rst_c", 32'(c), 32'd0);
      check("rst_busy", 32'(any_busy), 32'd0);
      check("rst_total", 32'(fire_total), 32'd0);
      reset_n = 1'b1;
      apply('0);
      check("rst_no_ack", 32'(c), 32'd0);

      // randomised traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         logic [2*N-1:0] v;
         for (int i = 0; i < N; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            v[2*i +: 2] = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
         end
         reset_n = ($urandom_range(0, 79) != 0);
         apply(v);
      end
      reset_n = 1'b1;
      apply('0);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
